// File: rtl/alu_issue_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_decoder
//  Description : Decodes RV32I register/immediate ALU instructions into ALU
//                commands. The decode is registered, and a two-entry skid
//                buffer (output register plus skid register) sits between the
//                valid/ready handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [4:0]  rd,
    output logic        rd_we,
    output logic        illegal
);

    localparam logic [6:0] c_OPC_REG = 7'b0110011;
    localparam logic [6:0] c_OPC_IMM = 7'b0010011;
    localparam logic [6:0] c_F7_ZERO = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    localparam logic [3:0] c_OP_ADD = 4'b0000;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_AND = 4'b0010;
    localparam logic [3:0] c_OP_OR  = 4'b0011;
    localparam logic [3:0] c_OP_XOR = 4'b0100;
    localparam logic [3:0] c_OP_SLL = 4'b0101;
    localparam logic [3:0] c_OP_SRL = 4'b0110;

    typedef struct packed {
        logic        illegal;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
    } cmd_t;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused_rs1_field;
    cmd_t       w_dec;

    cmd_t out_q, out_d;
    cmd_t skid_q, skid_d;
    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q;

    logic w_in_fire;
    logic w_out_fire;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    // The rs1 index is resolved upstream; only its data is consumed here.
    assign w_unused_rs1_field = ^instr[19:15];

    // in_ready is a registered "skid empty" flag, forced low while reset is held.
    assign in_ready   = in_ready_q & ~rst;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid_q & out_ready;

    assign out_valid = out_valid_q;
    assign alu_a     = out_q.a;
    assign alu_b     = out_q.b;
    assign alu_op    = out_q.op;
    assign rd        = out_q.rd;
    assign rd_we     = out_q.we;
    assign illegal   = out_q.illegal;

    // Combinational decode of the presented instruction into an ALU command.
    always_comb begin
        logic       legal;
        logic [3:0] op;
        logic [31:0] b;
        legal = 1'b0;
        op    = c_OP_ADD;
        b     = rs2_data;
        if (w_opcode == c_OPC_REG) begin
            b = rs2_data;
            if (w_funct7 == c_F7_ZERO) begin
                legal = 1'b1;
                case (w_funct3)
                    3'b000:  op = c_OP_ADD;
                    3'b001:  op = c_OP_SLL;
                    3'b100:  op = c_OP_XOR;
                    3'b101:  op = c_OP_SRL;
                    3'b110:  op = c_OP_OR;
                    3'b111:  op = c_OP_AND;
                    default: legal = 1'b0;   // SLT / SLTU
                endcase
            end else if (w_funct7 == c_F7_ALT && w_funct3 == 3'b000) begin
                legal = 1'b1;
                op    = c_OP_SUB;
            end
        end else if (w_opcode == c_OPC_IMM) begin
            b = {{20{instr[31]}}, instr[31:20]};
            legal = 1'b1;
            case (w_funct3)
                3'b000: op = c_OP_ADD;
                3'b100: op = c_OP_XOR;
                3'b110: op = c_OP_OR;
                3'b111: op = c_OP_AND;
                3'b001: begin
                    op    = c_OP_SLL;
                    b     = {27'b0, instr[24:20]};
                    legal = (w_funct7 == c_F7_ZERO);
                end
                3'b101: begin
                    op    = c_OP_SRL;
                    b     = {27'b0, instr[24:20]};
                    legal = (w_funct7 == c_F7_ZERO);   // SRAI rejected
                end
                default: legal = 1'b0;  // SLTI / SLTIU
            endcase
        end

        w_dec.illegal = ~legal;
        w_dec.op      = legal ? op : 4'b0000;
        w_dec.a       = legal ? rs1_data : 32'b0;
        w_dec.b       = legal ? b : 32'b0;
        w_dec.rd      = instr[11:7];
        w_dec.we      = legal && (instr[11:7] != 5'd0);
    end

    // Skid-buffer next state: skid drains first, then new commands fill the
    // output register if it is free (or emptying), otherwise the skid.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            if (w_out_fire) begin
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (w_in_fire) begin
            if (!out_valid_q || w_out_fire) begin
                out_d       = w_dec;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = w_dec;
                skid_valid_d = 1'b1;
            end
        end else if (w_out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset clearing both entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= ~skid_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_decoder
//  Description : Self-checking bench for alu_issue_decoder. A reference
//                decode feeds an in-order scoreboard; scenario tasks add
//                their own directed checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_decoder;

    typedef struct packed {
        logic        ill;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'b0;
    logic [31:0] rs1_data = 32'b0;
    logic [31:0] rs2_data = 32'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    exp_t sb[$];

    alu_issue_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .rd        (rd),
        .rd_we     (rd_we),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1,
                                   input logic [31:0] r2);
        exp_t e;
        logic ok;
        logic [3:0] op;
        logic [31:0] b;
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = ins[31:25];
        f3 = ins[14:12];
        ok = 1'b0;
        op = 4'd0;
        b  = 32'd0;
        if (ins[6:0] == 7'b0110011) begin
            b  = r2;
            ok = 1'b1;
            if      (f7 == 7'h00 && f3 == 3'd0) op = 4'd0;
            else if (f7 == 7'h20 && f3 == 3'd0) op = 4'd1;
            else if (f7 == 7'h00 && f3 == 3'd1) op = 4'd5;
            else if (f7 == 7'h00 && f3 == 3'd4) op = 4'd4;
            else if (f7 == 7'h00 && f3 == 3'd5) op = 4'd6;
            else if (f7 == 7'h00 && f3 == 3'd6) op = 4'd3;
            else if (f7 == 7'h00 && f3 == 3'd7) op = 4'd2;
            else ok = 1'b0;
        end else if (ins[6:0] == 7'b0010011) begin
            b  = {{20{ins[31]}}, ins[31:20]};
            ok = 1'b1;
            if      (f3 == 3'd0) op = 4'd0;
            else if (f3 == 3'd4) op = 4'd4;
            else if (f3 == 3'd6) op = 4'd3;
            else if (f3 == 3'd7) op = 4'd2;
            else if (f3 == 3'd1 && f7 == 7'h00) begin op = 4'd5; b = {27'd0, ins[24:20]}; end
            else if (f3 == 3'd5 && f7 == 7'h00) begin op = 4'd6; b = {27'd0, ins[24:20]}; end
            else ok = 1'b0;
        end
        e.ill = ~ok;
        e.op  = ok ? op : 4'd0;
        e.a   = ok ? r1 : 32'd0;
        e.b   = ok ? b : 32'd0;
        e.rd  = ins[11:7];
        e.we  = ok && (ins[11:7] != 5'd0);
        return e;
    endfunction

    // Scoreboard: pop/compare on each output transfer, push on each accept.
    always @(negedge clk) begin
        exp_t got, e;
        got = '{illegal, alu_op, alu_a, alu_b, rd, rd_we};
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h, required no output", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL sb_order: got %h, required %h", got, e);
                    end
                end
            end
            if (in_valid && in_ready)
                sb.push_back(model(instr, rs1_data, rs2_data));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready_low: got %b, required 0", in_ready);
        end
        n_tests++;
        if ({out_valid, illegal, alu_op, alu_a, alu_b, rd, rd_we} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b op=%h a=%h b=%h rd=%h we=%b ill=%b, required all 0",
                     out_valid, alu_op, alu_a, alu_b, rd, rd_we, illegal);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready_high: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_decode;
        logic [31:0] iv[8];
        logic [31:0] r1v[8];
        logic [31:0] r2v[8];
        exp_t ev[8];
        exp_t got;
        iv[0] = 32'h002081B3; r1v[0] = 32'd5;          r2v[0] = 32'd7;  ev[0] = '{1'b0, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1};
        iv[1] = 32'hFFF00293; r1v[1] = 32'd0;          r2v[1] = 32'd9;  ev[1] = '{1'b0, 4'd0, 32'd0, 32'hFFFFFFFF, 5'd5, 1'b1};
        iv[2] = 32'h01F0D093; r1v[2] = 32'h80000000;   r2v[2] = 32'd9;  ev[2] = '{1'b0, 4'd6, 32'h80000000, 32'd31, 5'd1, 1'b1};
        iv[3] = 32'h4020D0B3; r1v[3] = 32'd11;         r2v[3] = 32'd12; ev[3] = '{1'b1, 4'd0, 32'd0, 32'd0, 5'd1, 1'b0};
        iv[4] = 32'h00208033; r1v[4] = 32'd5;          r2v[4] = 32'd7;  ev[4] = '{1'b0, 4'd0, 32'd5, 32'd7, 5'd0, 1'b0};
        iv[5] = 32'h40208233; r1v[5] = 32'd20;         r2v[5] = 32'd3;  ev[5] = '{1'b0, 4'd1, 32'd20, 32'd3, 5'd4, 1'b1};
        iv[6] = 32'h0020A1B3; r1v[6] = 32'd1;          r2v[6] = 32'd2;  ev[6] = '{1'b1, 4'd0, 32'd0, 32'd0, 5'd3, 1'b0};
        iv[7] = 32'h4020F1B3; r1v[7] = 32'd1;          r2v[7] = 32'd2;  ev[7] = '{1'b1, 4'd0, 32'd0, 32'd0, 5'd3, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            instr    = iv[i];
            rs1_data = r1v[i];
            rs2_data = r2v[i];
            tick();
            in_valid = 1'b0;
            got = '{illegal, alu_op, alu_a, alu_b, rd, rd_we};
            n_tests++;
            if (out_valid !== 1'b1 || got !== ev[i]) begin
                n_fail++;
                $display("FAIL decode_%0d: got v=%b %h, required v=1 %h", i, out_valid, got, ev[i]);
            end
        end
        tick();
    endtask

    task automatic test_backpressure;
        int out0;
        out0 = n_out;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h002081B3;
        rs2_data  = 32'd100;
        rs1_data  = 32'd1;
        tick();
        rs1_data  = 32'd2;
        tick();
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready_drop: got %b, required 0", in_ready);
        end
        rs1_data = 32'd3;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || alu_a !== 32'd1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b a=%h rdy=%b, required v=1 a=1 rdy=0",
                     out_valid, alu_a, in_ready);
        end
        out_ready = 1'b1;
        tick();
        n_tests++;
        if (in_ready !== 1'b1 || alu_a !== 32'd2) begin
            n_fail++;
            $display("FAIL bp_skid_drain: got rdy=%b a=%h, required rdy=1 a=2", in_ready, alu_a);
        end
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || sb.size() != 0 || (n_out - out0) != 3) begin
            n_fail++;
            $display("FAIL bp_count: got v=%b pending=%0d outs=%0d, required v=0 pending=0 outs=3",
                     out_valid, sb.size(), n_out - out0);
        end
    endtask

    task automatic test_stream;
        logic [2:0] rf3[7];
        logic [6:0] rf7[7];
        logic [2:0] if3[4];
        logic [31:0] ins;
        exp_t e, got;
        int k;
        rf3 = '{3'd0, 3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        rf7 = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        if3 = '{3'd0, 3'd4, 3'd6, 3'd7};
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            k = $urandom_range(0, 12);
            if (k < 7)
                ins = {rf7[k], 5'($urandom), 5'($urandom), rf3[k], 5'($urandom), 7'b0110011};
            else if (k < 11)
                ins = {12'($urandom), 5'($urandom), if3[k-7], 5'($urandom), 7'b0010011};
            else
                ins = {7'h00, 5'($urandom), 5'($urandom), (k == 11) ? 3'd1 : 3'd5,
                       5'($urandom), 7'b0010011};
            in_valid = 1'b1;
            instr    = ins;
            rs1_data = $urandom;
            rs2_data = $urandom;
            e = model(instr, rs1_data, rs2_data);
            tick();
            got = '{illegal, alu_op, alu_a, alu_b, rd, rd_we};
            n_tests++;
            if (out_valid !== 1'b1 || got !== e) begin
                n_fail++;
                $display("FAIL stream_%0d: got v=%b %h, required v=1 %h", i, out_valid, got, e);
            end
        end
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_midop;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h00310233;
        rs1_data  = 32'hAA;
        rs2_data  = 32'hBB;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        n_tests++;
        if ({out_valid, illegal, alu_op, alu_a, alu_b, rd, rd_we} !== '0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_clear: got v=%b a=%h b=%h rd=%h rdy=%b, required all 0",
                     out_valid, alu_a, alu_b, rd, in_ready);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready: got %b, required 1", in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_stale_%0d: got out_valid=%b, required 0", i, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_stream();
        test_reset_midop();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
